// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the main control decoder used by the ID stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch_eq;
        logic       branch_ne;
        logic [2:0] alu_control;
    } ctrl_t;

    // Anything not recognised decodes to an all-zero NOP rather than trapping.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_control = ALU_ADD;
                    FN_SUB:  c.alu_control = ALU_SUB;
                    FN_AND:  c.alu_control = ALU_AND;
                    FN_OR:   c.alu_control = ALU_OR;
                    FN_SLT:  c.alu_control = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_LW: begin
                c.reg_write   = 1'b1;
                c.mem_to_reg  = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_ADDI: begin
                c.reg_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch_eq   = 1'b1;
                c.alu_control = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_ne   = 1'b1;
                c.alu_control = ALU_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports with write-through, one write port.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];

    // Entry 0 is never written, so it reads 0 without a special read mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    // Bypass the same-cycle WB write so ID never sees a stale value.
    always_comb begin
        rd1 = regs[ra1];
        if (we && wa == ra1 && ra1 != '0) rd1 = wd;
    end

    always_comb begin
        rd2 = regs[ra2];
        if (we && wa == ra2 && ra2 != '0) rd2 = wd;
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, early branch resolve, ID/EX register.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       InstrD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic              ForwardAD,
    input  logic              ForwardBD,
    input  logic              FlushE,
    output logic [DATA_W-1:0] PCBranchD,
    output logic              PCSrcD,
    output logic              BranchD,
    output logic [REG_AW-1:0] RsD,
    output logic [REG_AW-1:0] RtD,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [REG_AW-1:0] RsE,
    output logic [REG_AW-1:0] RtE,
    output logic [REG_AW-1:0] RdE,
    output logic [DATA_W-1:0] SignImmE
);

    ctrl_t             ctrl_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    logic [DATA_W-1:0] sign_imm_d;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic [REG_AW-1:0] rd_d;
    logic              equal_d;

    assign ctrl_d     = decode(InstrD[31:26], InstrD[5:0]);
    assign RsD        = InstrD[25:21];
    assign RtD        = InstrD[20:16];
    assign rd_d       = InstrD[15:11];
    assign sign_imm_d = {{(DATA_W-16){InstrD[15]}}, InstrD[15:0]};

    reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (RsD),
        .ra2   (RtD),
        .rd1   (rd1_d),
        .rd2   (rd2_d),
        .we    (RegWriteW),
        .wa    (WriteRegW),
        .wd    (ResultW)
    );

    // Early branch resolution; forwarding only affects the comparator, not RD1E/RD2E.
    assign cmp_a     = ForwardAD ? ALUOutM : rd1_d;
    assign cmp_b     = ForwardBD ? ALUOutM : rd2_d;
    assign equal_d   = (cmp_a == cmp_b);
    assign BranchD   = ctrl_d.branch_eq | ctrl_d.branch_ne;
    assign PCSrcD    = (ctrl_d.branch_eq & equal_d) | (ctrl_d.branch_ne & ~equal_d);
    assign PCBranchD = (sign_imm_d << 2) + PCPlus4D;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
            SignImmE    <= '0;
        end else begin
            // A flush only kills the control; data fields still track D for determinism.
            if (FlushE) begin
                RegWriteE   <= 1'b0;
                MemtoRegE   <= 1'b0;
                MemWriteE   <= 1'b0;
                ALUSrcE     <= 1'b0;
                RegDstE     <= 1'b0;
                ALUControlE <= '0;
            end else begin
                RegWriteE   <= ctrl_d.reg_write;
                MemtoRegE   <= ctrl_d.mem_to_reg;
                MemWriteE   <= ctrl_d.mem_write;
                ALUSrcE     <= ctrl_d.alu_src;
                RegDstE     <= ctrl_d.reg_dst;
                ALUControlE <= ctrl_d.alu_control;
            end
            RD1E     <= rd1_d;
            RD2E     <= rd2_d;
            RsE      <= RsD;
            RtE      <= RtD;
            RdE      <= rd_d;
            SignImmE <= sign_imm_d;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: driver queues hand-computed expectations, monitor checks them.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] InstrD = '0, PCPlus4D = '0, ResultW = '0, ALUOutM = '0;
    logic        RegWriteW = 1'b0, ForwardAD = 1'b0, ForwardBD = 1'b0, FlushE = 1'b0;
    logic [4:0]  WriteRegW = '0;
    logic [31:0] PCBranchD, RD1E, RD2E, SignImmE;
    logic        PCSrcD, BranchD, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [4:0]  RsD, RtD, RsE, RtE, RdE;
    logic [2:0]  ALUControlE;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .FlushE(FlushE),
        .PCBranchD(PCBranchD), .PCSrcD(PCSrcD), .BranchD(BranchD), .RsD(RsD), .RtD(RtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        branch, pcsrc;
        logic [31:0] pcbr;
        logic [4:0]  rs_d, rt_d;
        logic [4:0]  ctrl;
        logic [2:0]  aluc;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // ctrl = {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst}
    task automatic step(input string nm, input logic rst, input logic [31:0] instr,
                        input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                        input logic fa, input logic fb, input logic [31:0] aluoutm, input logic flush,
                        input logic branch, input logic pcsrc, input logic [31:0] pcbr,
                        input logic [4:0] ctrl, input logic [2:0] aluc,
                        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                        input logic [4:0] rd);
        exp_t e;
        @(negedge clk);
        rst_n = ~rst;  InstrD = instr;  PCPlus4D = 32'h40;
        RegWriteW = we; WriteRegW = wreg; ResultW = wdata;
        ForwardAD = fa; ForwardBD = fb; ALUOutM = aluoutm; FlushE = flush;
        e.name = nm; e.rst = rst; e.branch = branch; e.pcsrc = pcsrc; e.pcbr = pcbr;
        e.rs_d = instr[25:21]; e.rt_d = instr[20:16];
        e.ctrl = ctrl; e.aluc = aluc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.rd = rd;
        e.rs = rst ? 5'd0 : instr[25:21];
        e.rt = rst ? 5'd0 : instr[20:16];
        q.push_back(e);
    endtask

    // Driver: one row per cycle, PCPlus4D fixed at 0x40.
    initial begin
        //     name          rst instr        we wr   wdata        fa fb aluoutm flush br  src pcbr          ctrl      aluc    rd1           rd2           imm           rd
        step("reset",       1, 32'h01085020, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000140C0, 5'b00000, 3'b000, 32'h0,        32'h0,        32'h0,        5'd0);
        step("read_after_rst",0,32'h01085020,0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000140C0, 5'b10001, 3'b010, 32'h0,        32'h0,        32'h5020,     5'd10);
        step("wt_add",      0, 32'h01085020, 1, 8,  32'h1234,     0, 0, 32'h0,  0,  0,  0, 32'h000140C0, 5'b10001, 3'b010, 32'h1234,     32'h1234,     32'h5020,     5'd10);
        step("wt_zero",     0, 32'h00005020, 1, 0,  32'hDEAD,     0, 0, 32'h0,  0,  0,  0, 32'h000140C0, 5'b10001, 3'b010, 32'h0,        32'h0,        32'h5020,     5'd10);
        step("set_r1",      0, 32'h00000000, 1, 1,  32'd5,        0, 0, 32'h0,  0,  0,  0, 32'h00000040, 5'b00000, 3'b000, 32'h0,        32'h0,        32'h0,        5'd0);
        step("beq_taken",   0, 32'h10220003, 1, 2,  32'd5,        0, 0, 32'h0,  0,  1,  1, 32'h0000004C, 5'b00000, 3'b110, 32'd5,        32'd5,        32'h3,        5'd0);
        step("beq_not",     0, 32'h10220003, 1, 2,  32'd6,        0, 0, 32'h0,  0,  1,  0, 32'h0000004C, 5'b00000, 3'b110, 32'd5,        32'd6,        32'h3,        5'd0);
        step("bne_taken",   0, 32'h14220003, 0, 0,  32'h0,        0, 0, 32'h0,  0,  1,  1, 32'h0000004C, 5'b00000, 3'b110, 32'd5,        32'd6,        32'h3,        5'd0);
        step("clr_r1",      0, 32'h00000000, 1, 1,  32'd0,        0, 0, 32'h0,  0,  0,  0, 32'h00000040, 5'b00000, 3'b000, 32'h0,        32'h0,        32'h0,        5'd0);
        step("fwd_a",       0, 32'h10220003, 1, 2,  32'd7,        1, 0, 32'd7,  0,  1,  1, 32'h0000004C, 5'b00000, 3'b110, 32'd0,        32'd7,        32'h3,        5'd0);
        step("fwd_b",       0, 32'h10220003, 0, 0,  32'h0,        0, 1, 32'd0,  0,  1,  1, 32'h0000004C, 5'b00000, 3'b110, 32'd0,        32'd7,        32'h3,        5'd0);
        step("beq_neg",     0, 32'h1022FFFF, 0, 0,  32'h0,        0, 0, 32'h0,  0,  1,  0, 32'h0000003C, 5'b00000, 3'b110, 32'd0,        32'd7,        32'hFFFFFFFF, 5'd31);
        step("lw",          0, 32'h8C410010, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h00000080, 5'b11010, 3'b010, 32'd7,        32'd0,        32'h10,       5'd0);
        step("sw",          0, 32'hAC410010, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h00000080, 5'b00110, 3'b010, 32'd7,        32'd0,        32'h10,       5'd0);
        step("addi_neg",    0, 32'h20418000, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'hFFFE0040, 5'b10010, 3'b010, 32'd7,        32'd0,        32'hFFFF8000, 5'd16);
        step("sub",         0, 32'h00221822, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000060C8, 5'b10001, 3'b110, 32'd0,        32'd7,        32'h1822,     5'd3);
        step("and",         0, 32'h00221824, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000060D0, 5'b10001, 3'b000, 32'd0,        32'd7,        32'h1824,     5'd3);
        step("or",          0, 32'h00221825, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000060D4, 5'b10001, 3'b001, 32'd0,        32'd7,        32'h1825,     5'd3);
        step("slt",         0, 32'h0022182A, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000060E8, 5'b10001, 3'b111, 32'd0,        32'd7,        32'h182A,     5'd3);
        step("bad_funct",   0, 32'h00221821, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000060C4, 5'b00000, 3'b000, 32'd0,        32'd7,        32'h1821,     5'd3);
        step("flush",       0, 32'h01085020, 0, 0,  32'h0,        0, 0, 32'h0,  1,  0,  0, 32'h000140C0, 5'b00000, 3'b000, 32'h1234,     32'h1234,     32'h5020,     5'd10);
        step("bad_op",      0, 32'hFC210003, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h0000004C, 5'b00000, 3'b000, 32'd0,        32'd0,        32'h3,        5'd0);
        step("add_pre_rst", 0, 32'h01085020, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000140C0, 5'b10001, 3'b010, 32'h1234,     32'h1234,     32'h5020,     5'd10);
        step("rst_mid",     1, 32'h01085020, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000140C0, 5'b00000, 3'b000, 32'h0,        32'h0,        32'h0,        5'd0);
        step("regs_cleared",0, 32'h01085020, 0, 0,  32'h0,        0, 0, 32'h0,  0,  0,  0, 32'h000140C0, 5'b10001, 3'b010, 32'h0,        32'h0,        32'h5020,     5'd10);
        @(negedge clk);
        done = 1'b1;
    end

    // Monitor: mid-cycle checks of combinational outputs (and async reset), then E outputs after the edge.
    initial begin
        exp_t e;
        bit   finished = 1'b0;
        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clk);
            #3;
            if (q.size() == 0) begin
                if (done) finished = 1'b1;
            end else begin
                e = q.pop_front();
                if (e.rst) begin
                    cmp({e.name, ".async_ctrl"}, {27'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE}, 32'd0);
                    cmp({e.name, ".async_rd1"}, RD1E, 32'd0);
                    cmp({e.name, ".async_imm"}, SignImmE, 32'd0);
                    cmp({e.name, ".async_idx"}, {17'd0, RsE, RtE, RdE}, 32'd0);
                end
                cmp({e.name, ".BranchD"}, {31'd0, BranchD}, {31'd0, e.branch});
                cmp({e.name, ".PCSrcD"}, {31'd0, PCSrcD}, {31'd0, e.pcsrc});
                cmp({e.name, ".PCBranchD"}, PCBranchD, e.pcbr);
                cmp({e.name, ".RsD_RtD"}, {22'd0, RsD, RtD}, {22'd0, e.rs_d, e.rt_d});
                @(posedge clk);
                #1;
                cmp({e.name, ".ctrlE"}, {27'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE}, {27'd0, e.ctrl});
                cmp({e.name, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, e.aluc});
                cmp({e.name, ".RD1E"}, RD1E, e.rd1);
                cmp({e.name, ".RD2E"}, RD2E, e.rd2);
                cmp({e.name, ".SignImmE"}, SignImmE, e.imm);
                cmp({e.name, ".RsE_RtE_RdE"}, {17'd0, RsE, RtE, RdE}, {17'd0, e.rs, e.rt, e.rd});
                $display("[TB] txn %s: PCSrcD=%0b PCBranchD=%h ALUControlE=%b RD1E=%h RD2E=%h",
                         e.name, PCSrcD, PCBranchD, ALUControlE, RD1E, RD2E);
            end
        end
        if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
